reg_targetio_mux: RTL and testbench

- Register-bus slave that routes N_IO target IO pins between UART TX, GPIO register and auxiliary sources.
- Per-channel mode: Hi-Z, push-pull or open-drain.
- Mode changes use break-before-make turnaround.
- Inputs are synchronised; the block counts rising edges per channel and raises a one-cycle trigger on enabled edges.
- Sits beside reg_chipwhisperer on the shared reg_* bus. The top level owns the tristate buffers.

---
 rtl/reg_targetio_mux_pkg.sv | 39 +++
 rtl/reg_targetio_mux_if.sv | 27 ++
 rtl/reg_targetio_mux_channel.sv | 93 +++++++++
 rtl/reg_targetio_mux.sv | 135 +++++++++++++
 tb/tb_reg_targetio_mux.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_targetio_mux_pkg.sv
// Shared definitions for the target-IO pin mux: reg-bus widths, register
// offsets, pin mode encodings and the register length lookup.
package reg_targetio_mux_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_DATA_W = 8;
    localparam int REG_BCNT_W = 16;

    localparam int REG_MODE    = 0;
    localparam int REG_GPIO    = 1;
    localparam int REG_STATUS  = 2;
    localparam int REG_EDGECNT = 3;
    localparam int REG_TRIG    = 4;

    typedef enum logic [2:0] {
        MODE_HIZ     = 3'd0,
        MODE_UART_PP = 3'd1,
        MODE_UART_OD = 3'd2,
        MODE_GPIO_PP = 3'd3,
        MODE_GPIO_OD = 3'd4,
        MODE_AUX     = 3'd5
    } mode_e;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_TURN   = 1'b1
    } turn_state_e;

    function automatic logic [REG_BCNT_W-1:0] reg_len(input int off, input int n_io, input int cnt_w);
        case (off)
            REG_MODE:             return REG_BCNT_W'(n_io);
            REG_GPIO, REG_STATUS: return REG_BCNT_W'(1);
            REG_EDGECNT:          return REG_BCNT_W'(n_io * cnt_w / 8);
            REG_TRIG:             return REG_BCNT_W'(3);
            default:              return '0;
        endcase
    endfunction

endpackage

// File: rtl/reg_targetio_mux_if.sv
// Shared reg_* register bus as seen by one slave on the OR-combined bus.
interface reg_targetio_mux_if;
    import reg_targetio_mux_pkg::*;

    logic [REG_ADDR_W-1:0] reg_address;
    logic [REG_BCNT_W-1:0] reg_bytecnt;
    logic [REG_DATA_W-1:0] reg_datai;
    logic [REG_DATA_W-1:0] reg_datao;
    logic                  reg_read;
    logic                  reg_write;
    logic                  reg_addrvalid;
    logic [REG_ADDR_W-1:0] reg_hypaddress;
    logic [REG_BCNT_W-1:0] reg_hyplen;

    modport master (
        output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
               reg_addrvalid, reg_hypaddress,
        input  reg_datao, reg_hyplen
    );

    modport slave (
        input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
               reg_addrvalid, reg_hypaddress,
        output reg_datao, reg_hyplen
    );

endinterface

// File: rtl/reg_targetio_mux_channel.sv
// One target-IO channel: mode register with break-before-make turnaround,
// input synchroniser, registered edge detect, saturating edge counter, drive mux.
module targetio_channel
    import reg_targetio_mux_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_we,
    input  logic [2:0]       mode_wdata,
    input  logic             cnt_clr,
    input  logic             uart_tx,
    input  logic             gpio,
    input  logic             aux,
    input  logic             pin_in,
    output logic             pin_out,
    output logic             pin_oe,
    output logic [2:0]       mode,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cnt
);

    turn_state_e state;
    logic [3:0]  ta_cnt;
    logic [2:0]  act_mode;
    logic        s1, s2, s3;
    logic        drv, en;

    // mode holds the last written value; act_mode only follows it once the
    // forced Hi-Z window has elapsed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ACTIVE;
            ta_cnt   <= '0;
            mode     <= MODE_HIZ;
            act_mode <= MODE_HIZ;
        end else if (mode_we && mode_wdata != mode) begin
            mode   <= mode_wdata;
            state  <= ST_TURN;
            ta_cnt <= 4'(TURNAROUND);
        end else if (state == ST_TURN) begin
            if (ta_cnt <= 4'd1) begin
                state    <= ST_ACTIVE;
                act_mode <= mode;
                ta_cnt   <= '0;
            end else begin
                ta_cnt <= ta_cnt - 4'd1;
            end
        end
    end

    // Edges are registered once more so pin-to-trigger latency is three clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1, s2, s3} <= 3'b111;
            rise         <= 1'b0;
            fall         <= 1'b0;
            cnt          <= '0;
        end else begin
            s1   <= pin_in;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
            if (cnt_clr)
                cnt <= '0;
            else if (rise && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign level = s2;

    always_comb begin
        drv = 1'b0;
        en  = 1'b0;
        case (act_mode)
            MODE_UART_PP: begin drv = uart_tx; en = 1'b1;     end
            MODE_UART_OD: begin drv = 1'b0;    en = ~uart_tx; end
            MODE_GPIO_PP: begin drv = gpio;    en = 1'b1;     end
            MODE_GPIO_OD: begin drv = 1'b0;    en = ~gpio;    end
            MODE_AUX:     begin drv = aux;     en = 1'b1;     end
            default:      ;
        endcase
        pin_out = drv;
        pin_oe  = en & (state == ST_ACTIVE);
    end

endmodule

// File: rtl/reg_targetio_mux.sv
// Register-bus slave routing N_IO target pins between UART TX, GPIO and aux
// sources; register decode, readback and edge trigger live here.
module reg_targetio_mux
    import reg_targetio_mux_pkg::*;
#(
    parameter int         N_IO       = 4,
    parameter logic [5:0] BASE_ADDR  = 6'd40,
    parameter int         TURNAROUND = 2,
    parameter int         CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_i,
    reg_targetio_mux_if.slave    bus,
    input  logic                 uart_tx_i,
    input  logic [N_IO-1:0]      aux_i,
    input  logic [N_IO-1:0]      io_in,
    output logic [N_IO-1:0]      io_out,
    output logic [N_IO-1:0]      io_oe,
    output logic                 uart_rx_o,
    output logic                 trigger_o
);

    localparam int CNT_BYTES = N_IO * CNT_W / 8;

    logic [5:0]                   roff, hoff;
    logic                         wr_en, rd_en, cnt_clr;
    logic [N_IO-1:0]              mode_we, level, rise, fall;
    logic [N_IO-1:0]              gpio, rmask, fmask;
    logic [2:0]                   rx_sel;
    logic [N_IO-1:0][2:0]         mode;
    logic [N_IO-1:0][CNT_W-1:0]   cnt;
    logic [N_IO*CNT_W-1:0]        cnt_flat;
    logic [REG_DATA_W-1:0]        rd;
    logic                         unused_bits;

    // Offsets wrap in 6 bits, so anything outside BASE..BASE+4 decodes as >= 5.
    assign roff        = bus.reg_address - BASE_ADDR;
    assign hoff        = bus.reg_hypaddress - BASE_ADDR;
    assign wr_en       = bus.reg_write & bus.reg_addrvalid;
    assign rd_en       = bus.reg_read & bus.reg_addrvalid;
    assign cnt_clr     = wr_en && int'(roff) == REG_EDGECNT;
    assign cnt_flat    = cnt;
    assign unused_bits = ^bus.reg_datai;

    always_comb begin
        for (int n = 0; n < N_IO; n++)
            mode_we[n] = wr_en && int'(roff) == REG_MODE && bus.reg_bytecnt == REG_BCNT_W'(n);
    end

    for (genvar n = 0; n < N_IO; n++) begin : g_ch
        targetio_channel #(
            .TURNAROUND (TURNAROUND),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (reset_i),
            .mode_we    (mode_we[n]),
            .mode_wdata (bus.reg_datai[2:0]),
            .cnt_clr    (cnt_clr),
            .uart_tx    (uart_tx_i),
            .gpio       (gpio[n]),
            .aux        (aux_i[n]),
            .pin_in     (io_in[n]),
            .pin_out    (io_out[n]),
            .pin_oe     (io_oe[n]),
            .mode       (mode[n]),
            .level      (level[n]),
            .rise       (rise[n]),
            .fall       (fall[n]),
            .cnt        (cnt[n])
        );
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            gpio      <= '0;
            rmask     <= '0;
            fmask     <= '0;
            rx_sel    <= '0;
            trigger_o <= 1'b0;
        end else begin
            trigger_o <= |((rise & rmask) | (fall & fmask));
            if (wr_en) begin
                case (int'(roff))
                    REG_GPIO:
                        if (bus.reg_bytecnt == '0) gpio <= bus.reg_datai[N_IO-1:0];
                    REG_TRIG:
                        case (bus.reg_bytecnt)
                            16'd0:   rmask  <= bus.reg_datai[N_IO-1:0];
                            16'd1:   fmask  <= bus.reg_datai[N_IO-1:0];
                            16'd2:   rx_sel <= bus.reg_datai[2:0];
                            default: ;
                        endcase
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd = '0;
        if (rd_en) begin
            case (int'(roff))
                REG_MODE:
                    for (int n = 0; n < N_IO; n++)
                        if (bus.reg_bytecnt == REG_BCNT_W'(n)) rd = {5'b0, mode[n]};
                REG_GPIO:
                    if (bus.reg_bytecnt == '0) rd[N_IO-1:0] = gpio;
                REG_STATUS:
                    if (bus.reg_bytecnt == '0) rd[N_IO-1:0] = level;
                REG_EDGECNT:
                    for (int b = 0; b < CNT_BYTES; b++)
                        if (bus.reg_bytecnt == REG_BCNT_W'(b)) rd = cnt_flat[b*8 +: 8];
                REG_TRIG:
                    case (bus.reg_bytecnt)
                        16'd0:   rd[N_IO-1:0] = rmask;
                        16'd1:   rd[N_IO-1:0] = fmask;
                        16'd2:   rd = {5'b0, rx_sel};
                        default: ;
                    endcase
                default: ;
            endcase
        end
        bus.reg_datao  = rd;
        bus.reg_hyplen = reg_len(int'(hoff), N_IO, CNT_W);
    end

    // Out-of-range selects park RX at idle-high.
    always_comb begin
        uart_rx_o = 1'b1;
        for (int n = 0; n < N_IO; n++)
            if (rx_sel == 3'(n)) uart_rx_o = level[n];
    end

endmodule

// File: tb/tb_reg_targetio_mux.sv
// Directed bench for reg_targetio_mux: main instance (4 ch, 16-bit counters)
// plus a small instance (2 ch, 8-bit counters) for counter saturation.
module tb_reg_targetio_mux;
    import reg_targetio_mux_pkg::*;

    localparam logic [5:0] A_MODE = 6'd40;
    localparam logic [5:0] A_GPIO = 6'd41;
    localparam logic [5:0] A_STAT = 6'd42;
    localparam logic [5:0] A_ECNT = 6'd43;
    localparam logic [5:0] A_TRIG = 6'd44;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       uart_tx_i = 1'b1;
    logic [3:0] aux_i = '0, io_in = '0, io_out, io_oe;
    logic       uart_rx_o, trigger_o;
    logic [1:0] aux2 = '0, io_in2 = '0, io_out2, io_oe2;
    logic       uart_rx2, trig2;

    always #5 clk = ~clk;

    reg_targetio_mux_if bus ();
    reg_targetio_mux_if bus2 ();

    reg_targetio_mux #(.N_IO(4), .BASE_ADDR(6'd40), .TURNAROUND(2), .CNT_W(16)) dut (
        .clk(clk), .reset_i(reset_i), .bus(bus), .uart_tx_i(uart_tx_i), .aux_i(aux_i),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .uart_rx_o(uart_rx_o), .trigger_o(trigger_o));

    reg_targetio_mux #(.N_IO(2), .BASE_ADDR(6'd40), .TURNAROUND(1), .CNT_W(8)) dut2 (
        .clk(clk), .reset_i(reset_i), .bus(bus2), .uart_tx_i(uart_tx_i), .aux_i(aux2),
        .io_in(io_in2), .io_out(io_out2), .io_oe(io_oe2), .uart_rx_o(uart_rx2), .trigger_o(trig2));

    typedef struct { string tag; logic [15:0] want; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic set_bus(input bit d2, input logic [5:0] a, input logic [15:0] b,
                           input logic [7:0] d, input logic w, input logic r);
        if (d2) begin
            bus2.reg_address = a; bus2.reg_bytecnt = b; bus2.reg_datai = d;
            bus2.reg_write = w; bus2.reg_read = r; bus2.reg_addrvalid = w | r;
        end else begin
            bus.reg_address = a; bus.reg_bytecnt = b; bus.reg_datai = d;
            bus.reg_write = w; bus.reg_read = r; bus.reg_addrvalid = w | r;
        end
    endtask

    task automatic wr(input bit d2, input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
        @(negedge clk);
        set_bus(d2, a, b, d, 1'b1, 1'b0);
        @(negedge clk);
        set_bus(d2, a, b, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input bit d2, input logic [5:0] a, input logic [15:0] b,
                      input logic [7:0] want, input string tag);
        exp_t e;
        @(negedge clk);
        set_bus(d2, a, b, 8'h00, 1'b0, 1'b1);
        sb.push_back('{tag: tag, want: {8'h00, want}});
        #1;
        e = sb.pop_front();
        chk(e.tag, {24'h0, d2 ? bus2.reg_datao : bus.reg_datao}, {16'h0, e.want});
        set_bus(d2, a, b, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pulse2(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); io_in2[1] = 1'b1;
            @(negedge clk); io_in2[1] = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] hyp_exp [5];
        hyp_exp = '{16'd4, 16'd1, 16'd1, 16'd8, 16'd3};
        set_bus(1'b0, 6'd0, 16'd0, 8'd0, 1'b0, 1'b0);
        set_bus(1'b1, 6'd0, 16'd0, 8'd0, 1'b0, 1'b0);
        bus.reg_hypaddress = '0;
        bus2.reg_hypaddress = '0;

        // reset state
        #1 reset_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_oe", io_oe, 0);
        chk("rst_out", io_out, 0);
        chk("rst_trig", trigger_o, 0);
        chk("rst_rx", uart_rx_o, 1);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        // push-pull UART on ch0 with 2-cycle turnaround, then same-value rewrite
        wr(1'b0, A_MODE, 16'd0, 8'd1);
        chk("ta_oe_c1", io_oe[0], 0);
        @(posedge clk); #1 chk("ta_oe_c2", io_oe[0], 0);
        @(posedge clk); #1 chk("ta_oe_on", io_oe[0], 1);
        uart_tx_i = 1'b0; #1 chk("uart_pp_0", io_out[0], 0);
        uart_tx_i = 1'b1; #1 chk("uart_pp_1", io_out[0], 1);
        wr(1'b0, A_MODE, 16'd0, 8'd1);
        chk("rewrite_oe_a", io_oe[0], 1);
        @(posedge clk); #1 chk("rewrite_oe_b", io_oe[0], 1);
        rd(1'b0, A_MODE, 16'd0, 8'h01, "mode_rb");
        rd(1'b0, A_MODE, 16'd4, 8'h00, "mode_oob");

        // open-drain UART on ch1, then mode 5 written mid-turnaround reloads the count
        aux_i[1] = 1'b1;
        wr(1'b0, A_MODE, 16'd1, 8'd2);
        wr(1'b0, A_MODE, 16'd1, 8'd5);
        chk("reload_c1", io_oe[1], 0);
        @(posedge clk); #1 chk("reload_c2", io_oe[1], 0);
        @(posedge clk); #1 chk("reload_on", io_oe[1], 1);
        chk("aux_out", io_out[1], 1);
        wr(1'b0, A_MODE, 16'd1, 8'd2);
        repeat (3) @(posedge clk);
        uart_tx_i = 1'b0; #1 chk("uart_od_oe", {io_oe[1], io_out[1]}, 2'b10);
        uart_tx_i = 1'b1; #1 chk("uart_od_off", io_oe[1], 0);
        wr(1'b0, A_MODE, 16'd3, 8'd6);
        repeat (3) @(posedge clk); #1 chk("reserved_hiz", io_oe[3], 0);

        // open-drain GPIO on ch0
        wr(1'b0, A_MODE, 16'd0, 8'd4);
        repeat (3) @(posedge clk); #1;
        chk("gpio_od_low", {io_oe[0], io_out[0]}, 2'b10);
        wr(1'b0, A_GPIO, 16'd0, 8'h01);
        chk("gpio_od_high", io_oe[0], 0);
        rd(1'b0, A_GPIO, 16'd0, 8'h01, "gpio_rb");

        // rising-edge trigger on ch0, three clocks after the edge that samples it
        wr(1'b0, A_TRIG, 16'd0, 8'h01);
        @(negedge clk); io_in[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 chk($sformatf("rise_pre%0d", i), trigger_o, 0);
        end
        @(posedge clk); #1 chk("rise_pulse", trigger_o, 1);
        @(posedge clk); #1 chk("rise_end", trigger_o, 0);
        rd(1'b0, A_ECNT, 16'd0, 8'h01, "ecnt0_lo");
        rd(1'b0, A_ECNT, 16'd1, 8'h00, "ecnt0_hi");
        rd(1'b0, A_STAT, 16'd0, 8'h01, "status");

        // falling-edge trigger
        wr(1'b0, A_TRIG, 16'd1, 8'h01);
        @(negedge clk); io_in[0] = 1'b0;
        repeat (3) @(posedge clk); #1 chk("fall_pre", trigger_o, 0);
        @(posedge clk); #1 chk("fall_pulse", trigger_o, 1);
        rd(1'b0, A_ECNT, 16'd0, 8'h01, "ecnt_no_fall");

        // rx select
        chk("rx_ch0", uart_rx_o, 0);
        wr(1'b0, A_TRIG, 16'd2, 8'd5);
        chk("rx_oob_idle", uart_rx_o, 1);
        rd(1'b0, A_TRIG, 16'd2, 8'h05, "rxsel_rb");

        // length queries and unowned addresses
        for (int i = 0; i < 5; i++) begin
            bus.reg_hypaddress = A_MODE + 6'(i);
            #1 chk($sformatf("hyplen%0d", i), bus.reg_hyplen, hyp_exp[i]);
        end
        bus.reg_hypaddress = 6'd39; #1 chk("hyplen_below", bus.reg_hyplen, 0);
        bus.reg_hypaddress = 6'd45; #1 chk("hyplen_above", bus.reg_hyplen, 0);
        bus2.reg_hypaddress = A_ECNT; #1 chk("hyplen2_ecnt", bus2.reg_hyplen, 2);
        rd(1'b0, 6'd10, 16'd0, 8'h00, "unowned_rd");

        // saturation and clear-wins on the small instance, channel 1
        pulse2(10);
        rd(1'b1, A_ECNT, 16'd1, 8'h0A, "cnt2_ten");
        pulse2(250);
        rd(1'b1, A_ECNT, 16'd1, 8'hFF, "cnt2_sat");
        pulse2(1);
        rd(1'b1, A_ECNT, 16'd1, 8'hFF, "cnt2_sat_hold");
        rd(1'b1, A_ECNT, 16'd0, 8'h00, "cnt2_ch0");
        @(negedge clk); io_in2[1] = 1'b1;
        repeat (3) @(negedge clk);
        set_bus(1'b1, A_ECNT, 16'd0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        set_bus(1'b1, A_ECNT, 16'd0, 8'h00, 1'b0, 1'b0);
        rd(1'b1, A_ECNT, 16'd1, 8'h00, "clr_wins");

        // asynchronous reset while ch0 drives UART and the trigger is high
        wr(1'b0, A_MODE, 16'd0, 8'd1);
        repeat (3) @(posedge clk); #1 chk("pre_rst_oe", io_oe[0], 1);
        @(negedge clk); io_in[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_trig", trigger_o, 1);
        #2 reset_i = 1'b1;
        #1 chk("async_oe", io_oe, 0);
        chk("async_trig", trigger_o, 0);
        io_in = '0;
        @(negedge clk); reset_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 4; b++) rd(1'b0, A_MODE, 16'(b), 8'h00, $sformatf("post_mode%0d", b));
        rd(1'b0, A_GPIO, 16'd0, 8'h00, "post_gpio");
        rd(1'b0, A_STAT, 16'd0, 8'h00, "post_status");
        for (int b = 0; b < 8; b++) rd(1'b0, A_ECNT, 16'(b), 8'h00, $sformatf("post_ecnt%0d", b));
        for (int b = 0; b < 3; b++) rd(1'b0, A_TRIG, 16'(b), 8'h00, $sformatf("post_trig%0d", b));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
